freq_meter: RTL and testbench

Measures the frequency of an asynchronous external square wave by counting its rising edges over a fixed gate window of Clk cycles. This is the inverse of the team's clock divider: the divider turns a count into a frequency, and this block turns a frequency into a count. With the 50 MHz system clock and the default gate of 1 ms, the result reads directly in kHz. The result feeds the display and control logic as a registered value plus a one-cycle valid strobe.

---
 rtl/freq_meter_pkg.sv | 27 ++
 rtl/freq_meter_sync_edge_det.sv | 30 +++
 rtl/freq_meter.sv | 131 +++++++++++++
 tb/tb_freq_meter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency meter: state encoding, default
// parameter values and the gate-counter width helper.
package freq_meter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        GATE = 1'b1
    } state_e;

    localparam int GATE_VAL_DEF    = 50000;
    localparam int COUNT_W_DEF     = 16;
    localparam int SYNC_STAGES_DEF = 2;

    // Ceiling of log2, used to size the gate counter.
    function automatic int clog2_f(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/freq_meter_sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous input followed by a
// single-cycle rising-edge pulse. Reusable for buttons and similar inputs.
module sync_edge_det
    import freq_meter_pkg::*;
#(
    parameter int Stages = SYNC_STAGES_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic rise_o
);

    logic [Stages-1:0] sync_q;
    logic              prev_q;

    // Shift the async input through the synchronizer and keep one cycle of history.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[Stages-2:0], async_i};
            prev_q <= sync_q[Stages-1];
        end
    end

    assign rise_o = sync_q[Stages-1] & ~prev_q;

endmodule

// File: rtl/freq_meter.sv
// Frequency meter: counts synchronized rising edges of sig_in_i over
// contiguous gate windows of GateVal clock cycles and publishes the total.
//
// state | meaning
// IDLE  | not measuring, counters held at zero
// GATE  | window in progress, counting edges
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GateVal    = GATE_VAL_DEF,
    parameter int CountW     = COUNT_W_DEF,
    parameter int SyncStages = SYNC_STAGES_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              sig_in_i,
    input  logic              enable_i,
    output logic [CountW-1:0] count_o,
    output logic              count_valid_o,
    output logic              overflow_o,
    output logic              busy_o
);

    localparam int GateW = clog2_f(GateVal);
    localparam logic [GateW-1:0]  GATE_LAST = GateW'(GateVal - 1);
    localparam logic [CountW-1:0] EDGE_MAX  = '1;

    state_e              state_q, state_d;
    logic [GateW-1:0]    gate_q, gate_d;
    logic [CountW-1:0]   edge_q, edge_d;
    logic                sat_q, sat_d;
    logic [CountW-1:0]   count_q, count_d;
    logic                ovf_q, ovf_d;
    logic                valid_q, valid_d;
    logic                rise;
    logic [CountW-1:0]   edge_tot;
    logic                sat_tot;

    sync_edge_det #(
        .Stages (SyncStages)
    ) u_sync (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .async_i (sig_in_i),
        .rise_o  (rise)
    );

    // Edge total including this cycle's edge, saturating at the counter maximum.
    always_comb begin
        edge_tot = edge_q;
        sat_tot  = sat_q;
        if (rise) begin
            if (edge_q == EDGE_MAX) begin
                sat_tot = 1'b1;
            end else begin
                edge_tot = edge_q + CountW'(1);
            end
        end
    end

    // Next-state, counter and result logic.
    always_comb begin
        state_d = state_q;
        gate_d  = gate_q;
        edge_d  = edge_q;
        sat_d   = sat_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                gate_d = '0;
                edge_d = '0;
                sat_d  = 1'b0;
                if (enable_i) begin
                    state_d = GATE;
                end
            end
            GATE: begin
                if (!enable_i) begin
                    state_d = IDLE;
                    gate_d  = '0;
                    edge_d  = '0;
                    sat_d   = 1'b0;
                end else if (gate_q == GATE_LAST) begin
                    // Close the window and start the next one with no dead cycle.
                    count_d = edge_tot;
                    ovf_d   = sat_tot;
                    valid_d = 1'b1;
                    gate_d  = '0;
                    edge_d  = '0;
                    sat_d   = 1'b0;
                end else begin
                    gate_d = gate_q + GateW'(1);
                    edge_d = edge_tot;
                    sat_d  = sat_tot;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and result registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            gate_q  <= '0;
            edge_q  <= '0;
            sat_q   <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gate_q  <= gate_d;
            edge_q  <= edge_d;
            sat_q   <= sat_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign count_o       = count_q;
    assign count_valid_o = valid_q;
    assign overflow_o    = ovf_q;
    assign busy_o        = (state_q == GATE);

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: dut_a (1000-cycle gate, 16-bit count) and
// dut_b (100-cycle gate, 4-bit count) share one clock and one test signal.
module tb_freq_meter;

    typedef struct packed {
        logic [15:0] cnt;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_a_n, rst_b_n, sig, en_a, en_b;
    logic [15:0] count_a;
    logic [3:0]  count_b;
    logic        valid_a, ovf_a, busy_a;
    logic        valid_b, ovf_b, busy_b;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_a = -1;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a, e_b;

    freq_meter #(.GateVal(1000), .CountW(16), .SyncStages(2)) dut_a (
        .clk_i(clk), .rst_ni(rst_a_n), .sig_in_i(sig), .enable_i(en_a),
        .count_o(count_a), .count_valid_o(valid_a), .overflow_o(ovf_a), .busy_o(busy_a));

    freq_meter #(.GateVal(100), .CountW(4), .SyncStages(2)) dut_b (
        .clk_i(clk), .rst_ni(rst_b_n), .sig_in_i(sig), .enable_i(en_b),
        .count_o(count_b), .count_valid_o(valid_b), .overflow_o(ovf_b), .busy_o(busy_b));

    // 100 MHz-style clock, period 10
    always #5 clk = ~clk;

    // cycle counter for valid spacing
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    // scoreboard monitor for dut_a
    always @(negedge clk) begin
        if (valid_a === 1'b1) begin
            if (q_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_a unexpected valid, count %0d", count_a);
            end else begin
                e_a = q_a.pop_front();
                chk("count_a", 32'(count_a), 32'(e_a.cnt));
                chk("ovf_a", 32'(ovf_a), 32'(e_a.ovf));
            end
            if (last_a >= 0) chk("spacing_a", cyc - last_a, 1000);
            last_a = cyc;
        end
    end

    // scoreboard monitor for dut_b
    always @(negedge clk) begin
        if (valid_b === 1'b1) begin
            if (q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_b unexpected valid, count %0d", count_b);
            end else begin
                e_b = q_b.pop_front();
                chk("count_b", 32'(count_b), 32'(e_b.cnt));
                chk("ovf_b", 32'(ovf_b), 32'(e_b.ovf));
            end
        end
    end

    // Drive sig for n cycles; iteration i sits on the negedge after gate-start
    // posedge + (base+i). mode 1: window running, valid only at gate multiples.
    // mode 2: idle, no valid and not busy.
    task automatic drive(input bit which, input int per, input int at, input logic hold,
                         input int n, input int base, input int gate, input int mode);
        logic v, b;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            v = which ? valid_b : valid_a;
            b = which ? busy_b : busy_a;
            if (mode == 1) begin
                chk("valid_timing", 32'(v), 32'(((base + i) > 0) && (((base + i) % gate) == 0)));
                chk("busy_gated", 32'(b), 32'd1);
            end else if (mode == 2) begin
                chk("valid_idle", 32'(v), 32'd0);
                chk("busy_idle", 32'(b), 32'd0);
            end
            sig = hold || (i == at) || (per != 0 && (i % per) == 0);
        end
    endtask

    task automatic push_b(input int cnt, input logic ovf);
        q_b.push_back('{cnt: 16'(cnt), ovf: ovf});
    endtask

    initial begin
        sig = 1'b0; en_a = 1'b0; en_b = 1'b0; rst_a_n = 1'b0; rst_b_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_count_a", 32'(count_a), 0);
        chk("rst_valid_a", 32'(valid_a), 0);
        chk("rst_ovf_a",   32'(ovf_a),   0);
        chk("rst_busy_a",  32'(busy_a),  0);
        chk("rst_count_b", 32'(count_b), 0);
        chk("rst_busy_b",  32'(busy_b),  0);
        rst_a_n = 1'b1; rst_b_n = 1'b1;
        drive(1, 0, -1, 1'b0, 4, 0, 100, 2);

        // nominal: period 50 on a 1000-cycle gate gives 20 per window
        @(negedge clk); en_a = 1'b1;
        for (int k = 0; k < 3; k++) q_a.push_back('{cnt: 16'd20, ovf: 1'b0});
        drive(0, 50, -1, 1'b0, 3005, 0, 1000, 1);
        @(negedge clk); en_a = 1'b0;
        drive(0, 0, -1, 1'b0, 5, 0, 1000, 2);

        // saturation: 25 edges clamp to 15, then period 20 gives 5 with flag clear
        @(negedge clk); en_b = 1'b1;
        push_b(15, 1'b1); push_b(5, 1'b0);
        drive(1, 4, -1, 1'b0, 98, 0, 100, 1);
        drive(1, 20, -1, 1'b0, 100, 98, 100, 1);
        drive(1, 0, -1, 1'b0, 5, 198, 100, 1);
        @(negedge clk); en_b = 1'b0;
        drive(1, 0, -1, 1'b0, 5, 0, 100, 2);

        // boundary: edge detected in the last gate cycle
        @(negedge clk); en_b = 1'b1;
        push_b(1, 1'b0); push_b(0, 1'b0);
        drive(1, 0, 97, 1'b0, 203, 0, 100, 1);
        @(negedge clk); en_b = 1'b0;
        drive(1, 0, -1, 1'b0, 5, 0, 100, 2);

        // boundary: one cycle later lands in the next window
        @(negedge clk); en_b = 1'b1;
        push_b(0, 1'b0); push_b(1, 1'b0);
        drive(1, 0, 98, 1'b0, 203, 0, 100, 1);
        @(negedge clk); en_b = 1'b0;
        drive(1, 0, -1, 1'b0, 5, 0, 100, 2);

        // abort at gate cycle 60 after 7 edges
        @(negedge clk); en_b = 1'b1;
        drive(1, 9, -1, 1'b0, 60, 0, 100, 1);
        @(negedge clk); en_b = 1'b0; sig = 1'b0;
        @(negedge clk);
        chk("abort_busy",  32'(busy_b),  0);
        chk("abort_valid", 32'(valid_b), 0);
        chk("abort_count", 32'(count_b), 1);
        chk("abort_ovf",   32'(ovf_b),   0);
        drive(1, 0, -1, 1'b0, 5, 0, 100, 2);

        // re-enable: full window, period 10 gives 10
        @(negedge clk); en_b = 1'b1;
        push_b(10, 1'b0);
        drive(1, 10, -1, 1'b0, 150, 0, 100, 1);

        // reset at gate cycle 50 of the second window
        @(negedge clk); rst_b_n = 1'b0; sig = 1'b0;
        @(negedge clk);
        chk("mrst_count", 32'(count_b), 0);
        chk("mrst_ovf",   32'(ovf_b),   0);
        chk("mrst_valid", 32'(valid_b), 0);
        chk("mrst_busy",  32'(busy_b),  0);
        rst_b_n = 1'b1;
        push_b(10, 1'b0);
        drive(1, 10, -1, 1'b0, 105, 0, 100, 1);
        @(negedge clk); en_b = 1'b0;
        drive(1, 0, -1, 1'b0, 5, 0, 100, 2);

        // constant high input counts nothing
        drive(1, 0, -1, 1'b1, 4, 0, 100, 2);
        @(negedge clk); en_b = 1'b1;
        push_b(0, 1'b0); push_b(0, 1'b0);
        drive(1, 0, -1, 1'b1, 205, 0, 100, 1);
        @(negedge clk); en_b = 1'b0;

        // toggling input while disabled
        drive(1, 3, -1, 1'b0, 300, 0, 100, 2);

        chk("sb_a_drained", q_a.size(), 0);
        chk("sb_b_drained", q_b.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
